// File: rtl/rt_ibex_pcs_stack_ctrl.sv
// rt_ibex_pcs_stack_ctrl
//
// Hardware context stack for preemptible interrupt nesting. An interrupt
// acknowledge pushes a full register snapshot (mepc, mcause and the ABI
// caller-saved registers) together with the interrupt level. An mret pops
// the top entry and replays it to the register file restore port over
// one or more beats.
//
// Optional feature (compile-time macro PCS_LEVEL_CHECK_EN):
//   When defined, an ack that does not raise the interrupt level above the
//   current top entry is rejected and flagged as an error. Tail-chaining is
//   not affected. When undefined, every ack is accepted if there is room.
//
// Ports
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   irq_level_i     level of the interrupt being acknowledged
//   irq_ack_i       push request (single-cycle pulse)
//   irq_exit_i      pop request / mret (single-cycle pulse)
//   store_data_i    snapshot, sampled on an accepted push
//   restore_data_o  current beat; lane k carries reg beat*BeatRegs+k
//   restore_idx_o   current beat index
//   restore_en_o    beat valid
//   restore_last_o  final beat of the pop
//   restore_done_o  pulse one cycle after the final beat
//   busy_o          restore in progress
//   count_o         occupied entries
//   top_level_o     level tag of the top entry, 0 when empty
//   tailchain_o     pulse: ack and exit arrived together
//   err_o           sticky error (overflow, underflow, request while busy)
//
// States
//   state      | meaning
//   ST_IDLE    | accepting push / pop / tail-chain requests
//   ST_RESTORE | replaying the latched entry, one beat per cycle

module rt_ibex_pcs_stack_ctrl #(
    parameter int DataWidth     = 32,
    parameter int NrSavedRegs   = 18,
    parameter int Depth         = 4,
    parameter int BeatRegs      = 18,
    parameter int IrqLevelWidth = 8,
    localparam int Beats     = (NrSavedRegs + BeatRegs - 1) / BeatRegs,
    localparam int IdxWidth  = (Beats > 1) ? $clog2(Beats) : 1,
    localparam int CntWidth  = $clog2(Depth + 1),
    localparam int BeatWidth = BeatRegs * DataWidth
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [IrqLevelWidth-1:0]         irq_level_i,
    input  logic                             irq_ack_i,
    input  logic                             irq_exit_i,
    input  logic [NrSavedRegs*DataWidth-1:0] store_data_i,
    output logic [BeatWidth-1:0]             restore_data_o,
    output logic [IdxWidth-1:0]              restore_idx_o,
    output logic                             restore_en_o,
    output logic                             restore_last_o,
    output logic                             restore_done_o,
    output logic                             busy_o,
    output logic [CntWidth-1:0]              count_o,
    output logic [IrqLevelWidth-1:0]         top_level_o,
    output logic                             tailchain_o,
    output logic                             err_o
);

    localparam int SlotWidth  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int EntryWidth = NrSavedRegs * DataWidth;
    localparam int BufWidth   = Beats * BeatWidth;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RESTORE = 1'b1;

    logic [0:0]               state;
    logic [IdxWidth-1:0]      beat_idx;
    logic [CntWidth-1:0]      count;
    logic                     err;
    logic                     done;
    logic                     tailchain;
    logic [EntryWidth-1:0]    entries [Depth];
    logic [IrqLevelWidth-1:0] levels  [Depth];
    // Popped entry, zero-padded to a whole number of beats so the unused
    // lanes of the last beat read as 0.
    logic [BufWidth-1:0]      pop_buf;

    logic [SlotWidth-1:0]     push_slot;
    logic [SlotWidth-1:0]     top_slot;
    logic                     empty;
    logic                     full;
    logic [IrqLevelWidth-1:0] top_level;
    logic                     level_ok;
    logic                     idle;
    logic                     tail_req;
    logic                     ack_only;
    logic                     exit_only;
    logic                     push_en;
    logic                     pop_en;
    logic                     err_set;
    logic                     last_beat;
    logic [BeatWidth-1:0]     beat_data;

    assign push_slot = count[SlotWidth-1:0];
    assign top_slot  = SlotWidth'(count - CntWidth'(1));
    assign empty     = (count == '0);
    assign full      = (count == CntWidth'(Depth));
    assign top_level = empty ? '0 : levels[top_slot];

`ifdef PCS_LEVEL_CHECK_EN
    // Only a strictly higher level counts as a preemption.
    assign level_ok = empty || (irq_level_i > top_level);
`else
    assign level_ok = 1'b1;
`endif

    assign idle      = (state == ST_IDLE);
    // Ack+exit on an empty stack has nothing to chain onto: it is a plain ack.
    assign tail_req  = idle && irq_ack_i && irq_exit_i && !empty;
    assign ack_only  = idle && irq_ack_i && !tail_req;
    assign exit_only = idle && irq_exit_i && !irq_ack_i;
    assign push_en   = ack_only && !full && level_ok;
    assign pop_en    = exit_only && !empty;
    assign err_set   = (ack_only && (full || !level_ok))
                     || (exit_only && empty)
                     || (!idle && (irq_ack_i || irq_exit_i));
    assign last_beat = (state == ST_RESTORE) && (beat_idx == IdxWidth'(Beats - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            beat_idx  <= '0;
            count     <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            tailchain <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                levels[i] <= '0;
            end
        end else begin
            done      <= last_beat;
            tailchain <= tail_req;
            if (err_set) begin
                err <= 1'b1;
            end
            if (push_en) begin
                levels[push_slot] <= irq_level_i;
                count             <= count + CntWidth'(1);
            end
            // Tail-chain: the new handler inherits the saved context, only
            // its level tag changes.
            if (tail_req) begin
                levels[top_slot] <= irq_level_i;
            end
            if (pop_en) begin
                count <= count - CntWidth'(1);
            end
            case (state)
                ST_IDLE: begin
                    beat_idx <= '0;
                    if (pop_en) begin
                        state <= ST_RESTORE;
                    end
                end
                ST_RESTORE: begin
                    if (last_beat) begin
                        state    <= ST_IDLE;
                        beat_idx <= '0;
                    end else begin
                        beat_idx <= beat_idx + IdxWidth'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    beat_idx <= '0;
                end
            endcase
        end
    end

    // Snapshot storage is not reset; writes are held off while reset is high.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_en) begin
            entries[push_slot] <= store_data_i;
        end
        if (!rst_i && pop_en) begin
            pop_buf <= BufWidth'(entries[top_slot]);
        end
    end

    always_comb begin
        beat_data = '0;
        if (state == ST_RESTORE) begin
            beat_data = BeatWidth'(pop_buf >> (int'(beat_idx) * BeatWidth));
        end
    end

    assign restore_data_o = beat_data;
    assign restore_idx_o  = beat_idx;
    assign restore_en_o   = (state == ST_RESTORE);
    assign restore_last_o = last_beat;
    assign restore_done_o = done;
    assign busy_o         = (state == ST_RESTORE);
    assign count_o        = count;
    assign top_level_o    = top_level;
    assign tailchain_o    = tailchain;
    assign err_o          = err;

endmodule

// File: tb/tb_rt_ibex_pcs_stack_ctrl.sv
// Bench for rt_ibex_pcs_stack_ctrl. Two instances share one stimulus stream:
// dut_a restores in 3 beats (BeatRegs=6), dut_b in 5 beats (BeatRegs=4,
// partially filled last beat). Restore beats are checked by a scoreboard
// fed from a model stack of snapshots; control outputs are checked inline.

module tb_rt_ibex_pcs_stack_ctrl;

    localparam int DW = 32;
    localparam int NR = 18;
    localparam int SW = NR * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      irq_level = '0;
    logic            irq_ack = 1'b0;
    logic            irq_exit = 1'b0;
    logic [SW-1:0]   store_data = '0;

    logic [191:0]    data_a;
    logic [1:0]      idx_a;
    logic            en_a, last_a, done_a, busy_a, tc_a, err_a;
    logic [1:0]      cnt_a;
    logic [7:0]      top_a;

    logic [127:0]    data_b;
    logic [2:0]      idx_b;
    logic            en_b, last_b, done_b, busy_b, tc_b, err_b;
    logic [1:0]      cnt_b;
    logic [7:0]      top_b;

    rt_ibex_pcs_stack_ctrl #(
        .DataWidth(DW), .NrSavedRegs(NR), .Depth(2), .BeatRegs(6), .IrqLevelWidth(8)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .irq_level_i(irq_level), .irq_ack_i(irq_ack),
        .irq_exit_i(irq_exit), .store_data_i(store_data),
        .restore_data_o(data_a), .restore_idx_o(idx_a), .restore_en_o(en_a),
        .restore_last_o(last_a), .restore_done_o(done_a), .busy_o(busy_a),
        .count_o(cnt_a), .top_level_o(top_a), .tailchain_o(tc_a), .err_o(err_a)
    );

    rt_ibex_pcs_stack_ctrl #(
        .DataWidth(DW), .NrSavedRegs(NR), .Depth(2), .BeatRegs(4), .IrqLevelWidth(8)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .irq_level_i(irq_level), .irq_ack_i(irq_ack),
        .irq_exit_i(irq_exit), .store_data_i(store_data),
        .restore_data_o(data_b), .restore_idx_o(idx_b), .restore_en_o(en_b),
        .restore_last_o(last_b), .restore_done_o(done_b), .busy_o(busy_b),
        .count_o(cnt_b), .top_level_o(top_b), .tailchain_o(tc_b), .err_o(err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [255:0] data;
        logic         last;
    } beat_t;

    beat_t         q_a[$];
    beat_t         q_b[$];
    logic [SW-1:0] mstack[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] beat_of(input logic [SW-1:0] s, input int br, input int b);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < br; k++) begin
            if (b * br + k < NR) begin
                r[k*DW +: DW] = s[(b*br+k)*DW +: DW];
            end
        end
        return r;
    endfunction

    task automatic expect_beats(input logic [SW-1:0] s);
        beat_t e;
        for (int b = 0; b < 3; b++) begin
            e.idx = b; e.data = beat_of(s, 6, b); e.last = (b == 2);
            q_a.push_back(e);
        end
        for (int b = 0; b < 5; b++) begin
            e.idx = b; e.data = beat_of(s, 4, b); e.last = (b == 4);
            q_b.push_back(e);
        end
    endtask

    // Scoreboard side: every beat the DUT produces must match the front entry.
    always @(negedge clk) begin
        beat_t e;
        if (en_a === 1'b1) begin
            if (q_a.size() == 0) begin
                chk("a_spurious_beat", en_a, 1'b0);
            end else begin
                e = q_a.pop_front();
                chk("a_beat_idx", idx_a, e.idx);
                chk("a_beat_last", last_a, e.last);
                chk("a_beat_data", data_a, e.data);
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (en_b === 1'b1) begin
            if (q_b.size() == 0) begin
                chk("b_spurious_beat", en_b, 1'b0);
            end else begin
                e = q_b.pop_front();
                chk("b_beat_idx", idx_b, e.idx);
                chk("b_beat_last", last_b, e.last);
                chk("b_beat_data", data_b, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        mstack.delete();
    endtask

    task automatic do_ack(input logic [7:0] lvl, input bit accept);
        logic [SW-1:0] s;
        for (int r = 0; r < NR; r++) begin
            s[r*DW +: DW] = $urandom;
        end
        store_data = s;
        irq_level  = lvl;
        irq_ack    = 1'b1;
        if (accept) begin
            mstack.push_back(s);
        end
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_exit();
        if (mstack.size() > 0) begin
            expect_beats(mstack.pop_back());
        end
        irq_exit = 1'b1;
        tick();
        irq_exit = 1'b0;
    endtask

    task automatic status(input string tag, input int cnt, input int top, input bit e, input bit busy);
        chk({tag, "_cnt_a"}, cnt_a, cnt);
        chk({tag, "_cnt_b"}, cnt_b, cnt);
        chk({tag, "_top_a"}, top_a, top);
        chk({tag, "_top_b"}, top_b, top);
        chk({tag, "_err_a"}, err_a, e);
        chk({tag, "_err_b"}, err_b, e);
        chk({tag, "_busy_a"}, busy_a, busy);
        chk({tag, "_busy_b"}, busy_b, busy);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_qa_left"}, q_a.size(), 0);
        chk({tag, "_qb_left"}, q_b.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        status("rst", 0, 0, 0, 0);
        chk("rst_data_a", data_a, 0);
        chk("rst_data_b", data_b, 0);
        chk("rst_en_a", en_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_tc_a", tc_a, 0);
        chk("rst_idx_b", idx_b, 0);

        // Two pushes then a pop: beat timing and done latency
        do_ack(8'd3, 1'b1);
        status("push_a", 1, 3, 0, 0);
        do_ack(8'd5, 1'b1);
        status("push_b", 2, 5, 0, 0);
        do_exit();
        chk("pop_cnt_a", cnt_a, 1);
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("t%0d_en_a", c), en_a, c <= 3);
            chk($sformatf("t%0d_en_b", c), en_b, c <= 5);
            chk($sformatf("t%0d_last_a", c), last_a, c == 3);
            chk($sformatf("t%0d_last_b", c), last_b, c == 5);
            chk($sformatf("t%0d_done_a", c), done_a, c == 4);
            chk($sformatf("t%0d_done_b", c), done_b, c == 6);
            tick();
        end
        status("after_pop", 1, 3, 0, 0);
        drained("pop1");
        do_exit();
        repeat (7) tick();
        status("pop_all", 0, 0, 0, 0);
        drained("pop2");

        // Overflow: third push dropped, next pop returns B
        do_ack(8'd3, 1'b1);
        do_ack(8'd5, 1'b1);
        do_ack(8'd6, 1'b0);
        status("ovf", 2, 5, 1, 0);
        do_exit();
        repeat (7) tick();
        status("ovf_pop", 1, 3, 1, 0);
        drained("ovf");

        // Underflow: no beats at all
        do_reset();
        do_exit();
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("unf%0d_en_a", c), en_a, 0);
            chk($sformatf("unf%0d_en_b", c), en_b, 0);
            chk($sformatf("unf%0d_done_a", c), done_a, 0);
            tick();
        end
        status("unf", 0, 0, 1, 0);

        // Tail-chain at count=1
        do_reset();
        do_ack(8'd2, 1'b1);
        irq_level = 8'd7;
        irq_ack   = 1'b1;
        irq_exit  = 1'b1;
        tick();
        irq_ack  = 1'b0;
        irq_exit = 1'b0;
        chk("tc_pulse_a", tc_a, 1);
        chk("tc_pulse_b", tc_b, 1);
        status("tc", 1, 7, 0, 0);
        tick();
        chk("tc_end_a", tc_a, 0);
        chk("tc_noen_a", en_a, 0);
        chk("tc_noen_b", en_b, 0);

        // Ack while restoring: flagged, beats keep going
        do_exit();
        tick();
        tick();
        chk("busy_ack_pre_err", err_b, 0);
        chk("busy_ack_idx_a", idx_a, 2);
        chk("busy_ack_idx_b", idx_b, 2);
        irq_level = 8'd9;
        irq_ack   = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("busy_ack_err_a", err_a, 1);
        chk("busy_ack_err_b", err_b, 1);
        chk("busy_ack_done_a", done_a, 1);
        chk("busy_ack_en_b", en_b, 1);
        chk("busy_ack_idx_b3", idx_b, 3);
        repeat (5) tick();
        status("busy_ack", 0, 0, 1, 0);
        drained("busy_ack");

        // Reset in the middle of a restore
        do_reset();
        do_ack(8'd3, 1'b1);
        do_ack(8'd5, 1'b1);
        do_exit();
        tick();
        chk("mid_rst_idx_a", idx_a, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        mstack.delete();
        chk("mid_rst_en_a", en_a, 0);
        chk("mid_rst_en_b", en_b, 0);
        status("mid_rst", 0, 0, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("mid_rst%0d_done_a", c), done_a, 0);
            chk($sformatf("mid_rst%0d_done_b", c), done_b, 0);
            chk($sformatf("mid_rst%0d_en_b", c), en_b, 0);
            tick();
        end

        // Non-increasing level ack
        do_reset();
        do_ack(8'd5, 1'b1);
`ifdef PCS_LEVEL_CHECK_EN
        do_ack(8'd4, 1'b0);
        status("lvl", 1, 5, 1, 0);
`else
        do_ack(8'd4, 1'b1);
        status("lvl", 2, 4, 0, 0);
`endif
        do_exit();
        repeat (7) tick();
        drained("lvl");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
